urng_64: RTL and testbench

URNG_64 -- requirements
Module: urng_64

---
 rtl/urng_64.sv | 91 +++++++++
 tb/tb_urng_64.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/urng_64.sv
// urng_64: five-component combined Tausworthe uniform random number generator
// (L'Ecuyer lfsr258). It produces one registered 64-bit sample per enabled clock.
//
// Output handshake: valid is a registered strobe with no backpressure.
// valid is high for one cycle exactly when data_out was loaded on the
// preceding rising edge. A consumer that does not take data_out in that
// cycle loses the sample. data_out holds its value while valid is low.
module urng_64 #(
  parameter logic [63:0] SEED1 = 64'h0123456789ABCDEF,
  parameter logic [63:0] SEED2 = 64'hFEDCBA9876543210,
  parameter logic [63:0] SEED3 = 64'h0F1E2D3C4B5A6978,
  parameter logic [63:0] SEED4 = 64'h8796A5B4C3D2E1F0,
  parameter logic [63:0] SEED5 = 64'h5555AAAA3333CCCC
) (
  input  logic        clk,
  input  logic        rstn,      // active-high asynchronous reset despite the name
  input  logic        en,
  output logic [63:0] data_out,
  output logic        valid
);

  // A component whose seed leaves every bit under its mask clear gets stuck.
  // Such a seed is rejected at elaboration rather than left to misbehave silently.
  if (SEED1 <= 64'd1) begin : g_bad_seed1
    $error("urng_64: SEED1 must be greater than 1");
  end
  if (SEED2 <= 64'd511) begin : g_bad_seed2
    $error("urng_64: SEED2 must be greater than 511");
  end
  if (SEED3 <= 64'd4095) begin : g_bad_seed3
    $error("urng_64: SEED3 must be greater than 4095");
  end
  if (SEED4 <= 64'd131071) begin : g_bad_seed4
    $error("urng_64: SEED4 must be greater than 131071");
  end
  if (SEED5 <= 64'd8388607) begin : g_bad_seed5
    $error("urng_64: SEED5 must be greater than 8388607");
  end

  logic [63:0] r_z1, r_z2, r_z3, r_z4, r_z5;
  logic [63:0] r_data;
  logic        r_valid;

  logic [63:0] w_b1, w_b2, w_b3, w_b4, w_b5;
  logic [63:0] w_z1_nxt, w_z2_nxt, w_z3_nxt, w_z4_nxt, w_z5_nxt;
  logic [63:0] w_sample;

  // Next state of every component. All shifts are logical and drop the bits
  // shifted past bit 63. The output is taken from the new state.
  always_comb begin
    w_b1     = ((r_z1 << 1)  ^ r_z1) >> 53;
    w_z1_nxt = ((r_z1 & 64'hFFFFFFFFFFFFFFFE) << 10) ^ w_b1;
    w_b2     = ((r_z2 << 24) ^ r_z2) >> 50;
    w_z2_nxt = ((r_z2 & 64'hFFFFFFFFFFFFFE00) << 5)  ^ w_b2;
    w_b3     = ((r_z3 << 3)  ^ r_z3) >> 23;
    w_z3_nxt = ((r_z3 & 64'hFFFFFFFFFFFFF000) << 29) ^ w_b3;
    w_b4     = ((r_z4 << 5)  ^ r_z4) >> 24;
    w_z4_nxt = ((r_z4 & 64'hFFFFFFFFFFFE0000) << 23) ^ w_b4;
    w_b5     = ((r_z5 << 3)  ^ r_z5) >> 33;
    w_z5_nxt = ((r_z5 & 64'hFFFFFFFFFF800000) << 8)  ^ w_b5;
    w_sample = w_z1_nxt ^ w_z2_nxt ^ w_z3_nxt ^ w_z4_nxt ^ w_z5_nxt;
  end

  // State and output registers. On an enabled edge the generator advances and
  // loads a sample. Otherwise everything holds and only valid drops.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_z1    <= SEED1;
      r_z2    <= SEED2;
      r_z3    <= SEED3;
      r_z4    <= SEED4;
      r_z5    <= SEED5;
      r_data  <= 64'h0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_z1    <= w_z1_nxt;
      r_z2    <= w_z2_nxt;
      r_z3    <= w_z3_nxt;
      r_z4    <= w_z4_nxt;
      r_z5    <= w_z5_nxt;
      r_data  <= w_sample;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign data_out = r_data;
  assign valid    = r_valid;

endmodule

// File: tb/tb_urng_64.sv
// tb_urng_64: directed stimulus on urng_64 with a per-cycle scoreboard.
// The driver pushes the expected {valid, data_out} for every edge it drives.
// The monitor pops each entry on the next falling edge and compares it.
// A second instance with SEED3 = 4096 runs in lockstep against its own model.
module tb_urng_64;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [63:0] data_out, data2;
  logic        valid, valid2;

  always #5 clk = ~clk;

  urng_64 u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .data_out (data_out),
    .valid    (valid)
  );

  urng_64 #(.SEED3(64'd4096)) u_dut_s3 (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .data_out (data2),
    .valid    (valid2)
  );

  // ---------------- reference model ----------------
  logic [63:0] m_z [2][5];
  logic [63:0] m_out [2];
  logic [63:0] saved [50];
  int          n_cmp = 0;
  int          n_err = 0;

  // Generic Tausworthe step: q = feedback shift, s = right shift,
  // low = number of low bits cleared by the mask, sh = state left shift.
  function automatic logic [63:0] taus(input logic [63:0] z, input int q,
                                       input int s, input int low, input int sh);
    logic [63:0] mask;
    logic [63:0] b;
    mask = {64{1'b1}} << low;
    b    = ((z << q) ^ z) >> s;
    return ((z & mask) << sh) ^ b;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_z[j][0] = 64'h0123456789ABCDEF;
      m_z[j][1] = 64'hFEDCBA9876543210;
      m_z[j][2] = (j == 0) ? 64'h0F1E2D3C4B5A6978 : 64'd4096;
      m_z[j][3] = 64'h8796A5B4C3D2E1F0;
      m_z[j][4] = 64'h5555AAAA3333CCCC;
      m_out[j]  = 64'h0;
    end
  endtask

  task automatic model_advance();
    for (int j = 0; j < 2; j++) begin
      m_z[j][0] = taus(m_z[j][0], 1, 53, 1, 10);
      m_z[j][1] = taus(m_z[j][1], 24, 50, 9, 5);
      m_z[j][2] = taus(m_z[j][2], 3, 23, 12, 29);
      m_z[j][3] = taus(m_z[j][3], 5, 24, 17, 23);
      m_z[j][4] = taus(m_z[j][4], 3, 33, 23, 8);
      m_out[j]  = m_z[j][0] ^ m_z[j][1] ^ m_z[j][2] ^ m_z[j][3] ^ m_z[j][4];
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  logic [64:0] exp2_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one entry per driven edge, compared mid-cycle.
  always @(negedge clk) begin
    logic [64:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("valid", {63'b0, valid}, {63'b0, e[64]});
      check("data_out", data_out, e[63:0]);
    end
    if (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      check("seed3_valid", {63'b0, valid2}, {63'b0, e[64]});
      check("seed3_data", data2, e[63:0]);
    end
  end

  // ---------------- driver tasks ----------------
  // Drive en for one edge, then push the outcome the model predicts for that edge.
  task automatic step(input logic v);
    en = v;
    @(posedge clk);
    #1;
    if (rstn) begin
      exp_q.push_back({1'b0, 64'h0});
      exp2_q.push_back({1'b0, 64'h0});
    end else if (v) begin
      model_advance();
      exp_q.push_back({1'b1, m_out[0]});
      exp2_q.push_back({1'b1, m_out[1]});
    end else begin
      exp_q.push_back({1'b0, m_out[0]});
      exp2_q.push_back({1'b0, m_out[1]});
    end
  endtask

  // Enabled edge whose expected sample comes from the first run, not the model.
  task automatic step_saved(input int i);
    en = 1'b1;
    @(posedge clk);
    #1;
    model_advance();
    exp_q.push_back({1'b1, saved[i]});
    exp2_q.push_back({1'b1, m_out[1]});
  endtask

  // Assert reset away from any clock edge and check that it acts without one.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check({tag, "_async_data"}, data_out, 64'h0);
    check({tag, "_async_valid"}, {63'b0, valid}, 64'h0);
    model_reset();
  endtask

  // ---------------- directed stimulus ----------------
  logic [3:0]  gate_vec = 4'b1001;        // applied MSB first: 1,0,0,1
  logic [15:0] mix_vec  = 16'b1101_0011_1000_1110;

  initial begin
    model_reset();
    #2;
    rstn = 1'b1;
    #1;
    check("por_data", data_out, 64'h0);
    check("por_valid", {63'b0, valid}, 64'h0);

    // en is ignored during reset: three edges with en=1 must leave outputs at zero
    for (int i = 0; i < 3; i++) step(1'b1);
    rstn = 1'b0;

    // first run of 50 samples, recorded for the mid-run reset test
    for (int i = 0; i < 50; i++) begin
      step(1'b1);
      saved[i] = m_out[0];
    end

    // mid-run reset: the second run must repeat the first one exactly
    async_reset("mid");
    step(1'b1);
    rstn = 1'b0;
    for (int i = 0; i < 50; i++) step_saved(i);

    // en gating 1,0,0,1: data is frozen while en is low, and the 4th edge gives sample #2
    async_reset("gate");
    step(1'b1);
    rstn = 1'b0;
    for (int i = 3; i >= 0; i--) step(gate_vec[i]);
    check("gate_sample2", data_out, saved[1]);

    // irregular enable pattern, then a long run at one sample per clock
    for (int i = 15; i >= 0; i--) step(mix_vec[i]);
    for (int i = 0; i < 1000; i++) step(1'b1);
    step(1'b0);

    // let the monitor drain. Anything left over was never compared.
    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size() + exp2_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so that a broken run still ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
